fifo_sync_param: RTL
====================

Name: fifo_sync_param

Overview:
- Single-clock, parametrised valid/ready FIFO.
- Generalises the 2-entry handshake buffer to arbitrary data width and power-of-two depth.
- Adds occupancy count, almost-full/almost-empty flags, synchronous flush and a peak-occupancy watermark.
- Sits between same-clock producer/consumer stages (bus bridges, DMA, accelerator ports) where no CDC is required.

Parameters:
- DATA_W, 10, payload width in bits.
- DEPTH, 4, number of entries; power of two, >= 2.
- AFULL_THR, 3, almost_full asserts when count >= AFULL_THR; range 1..DEPTH.
- AEMPTY_THR, 1, almost_empty asserts when count <= AEMPTY_THR; range 0..DEPTH-1.
- CW (derived), $clog2(DEPTH)+1, width of count and watermark.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wdata  in  DATA_W  write payload.
- valid_i  in  1  producer has data.
- ready_o  out  1  FIFO can accept; high when not full.
- rdata  out  DATA_W  head-of-queue payload, first-word-fall-through.
- valid_o  out  1  FIFO holds data; high when not empty.
- ready_i  in  1  consumer accepts head.
- flush  in  1  synchronous discard of all contents.
- wm_clr  in  1  synchronous clear of watermark.
- count  out  CW  current occupancy, 0..DEPTH.
- almost_full  out  1  count >= AFULL_THR.
- almost_empty  out  1  count <= AEMPTY_THR.
- watermark  out  CW  maximum count reached since reset or last wm_clr.

Behaviour:
- Reset (rst high, asynchronous):
  - wptr, rptr, count, watermark all 0.
  - All memory entries 0.
  - Outputs: valid_o=0, ready_o=1, rdata=0, almost_empty=1.
  - almost_full=0 (AFULL_THR >= 1 guarantees this).
- Pointers: wptr and rptr are CW bits wide. Low bits index memory; MSB is the wrap bit.
  - empty: wptr == rptr.
  - full: low bits equal, MSBs differ.
- ready_o = ~full; valid_o = ~empty. Both are combinational from registered pointers only. Neither depends on valid_i or ready_i (no combinational loop).
- Push: push = valid_i & ready_o. On clk edge, writes mem[wptr low bits] <= wdata and increments wptr.
- Pop: pop = valid_o & ready_i. On clk edge, increments rptr.
- rdata = mem[rptr low bits], combinational read.
  - A pushed word is visible on rdata/valid_o one cycle after its push edge.
  - No same-cycle bypass when empty.
- Simultaneous push and pop (legal only when 0 < count < DEPTH): both pointers advance and count is unchanged.
  - When full, push is blocked by ready_o=0; a pop that cycle frees a slot visible next cycle.
  - When empty, pop is blocked by valid_o=0.
- Pointer wrap: natural binary roll-over of the CW-bit pointers. No special case.
- count: next value = count + push - pop; equals wptr - rptr modulo 2^CW.
- almost_full and almost_empty are decoded combinationally from registered count.
- flush (priority over push/pop in the same cycle):
  - Next cycle: rptr <= wptr, count=0, valid_o=0, ready_o=1.
  - Any push in the flush cycle is discarded; memory contents are left unchanged.
  - Watermark is unaffected.
- watermark: each cycle, if next count > watermark, watermark <= next count.
  - wm_clr loads the next count value, so concurrent occupancy is not lost.
  - Saturates naturally at DEPTH.
- Data-path contract for the bench: rdata is checked only when valid_o=1. Data order is strict FIFO with no loss or duplication.

Test Plan:
- Reset mid-traffic: fill 2 words, assert rst mid-cycle -> immediately valid_o=0, ready_o=1, count=0, watermark=0, rdata=0.
- Fill to full (DEPTH=4): push 0x001..0x004 with ready_i=0 -> ready_o=0 after 4th edge, count=4, almost_full=1 from count=3; 5th word 0x005 not accepted.
- Drain and ordering: from full, ready_i=1 for 4 cycles -> rdata sequence 0x001,0x002,0x003,0x004; then valid_o=0, almost_empty=1 at count<=1.
- Wrap and simultaneous: stream 12 words (0x100..0x10B) with valid_i=ready_i=1 continuously after the first push -> count holds 1, pointers wrap 3 times, output order intact with no gaps.
- Full with simultaneous pop: count=4, valid_i=1, ready_i=1 -> pop only, count=3; next cycle ready_o=1 and the push is accepted.
- Flush and watermark: push 3 words (watermark=3), assert flush with a concurrent push -> count=0, valid_o=0, watermark=3; then wm_clr with 1 push in the same cycle -> watermark=1.

Source files
------------

// File: rtl/fifo_sync_param_if.sv
// Handshake bundle for fifo_sync_param: producer and consumer valid/ready,
// control strobes and status outputs.
interface fifo_sync_param_if #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned CW     = 3
);
    logic [DATA_W-1:0] wdata;
    logic              valid_i;
    logic              ready_o;
    logic [DATA_W-1:0] rdata;
    logic              valid_o;
    logic              ready_i;
    logic              flush;
    logic              wm_clr;
    logic [CW-1:0]     count;
    logic              almost_full;
    logic              almost_empty;
    logic [CW-1:0]     watermark;

    // Environment side: drives payload, handshakes and control strobes
    modport master (
        output wdata, valid_i, ready_i, flush, wm_clr,
        input  ready_o, rdata, valid_o, count, almost_full, almost_empty, watermark
    );

    // FIFO side
    modport slave (
        input  wdata, valid_i, ready_i, flush, wm_clr,
        output ready_o, rdata, valid_o, count, almost_full, almost_empty, watermark
    );
endinterface

// File: rtl/fifo_sync_param.sv
// Single-clock first-word-fall-through FIFO with occupancy count,
// almost-full/empty flags, synchronous flush and peak-occupancy watermark.
module fifo_sync_param #(
    parameter int unsigned DATA_W     = 10,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned AFULL_THR  = 3,
    parameter int unsigned AEMPTY_THR = 1,
    localparam int unsigned CW        = $clog2(DEPTH) + 1
) (
    input logic               clk,
    input logic               rst,
    fifo_sync_param_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [CW-1:0]     wptr_q, wptr_d;
    logic [CW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     wm_q, wm_d;

    logic full, empty, push, pop;

    // Status from registered pointers only; no path from valid_i/ready_i
    always_comb begin
        empty = (wptr_q == rptr_q);
        full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[CW-1] != rptr_q[CW-1]);
        push  = bus.valid_i & ~full;
        pop   = bus.ready_i & ~empty;
    end

    // Next-state: flush wins over push/pop and leaves memory untouched
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (bus.flush) begin
            rptr_d  = wptr_q;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[wptr_q[AW-1:0]] = bus.wdata;
                wptr_d                = wptr_q + CW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + CW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Watermark tracks peak of next count; clear reloads it so current fill is kept
    always_comb begin
        wm_d = wm_q;
        if (bus.wm_clr) begin
            wm_d = count_d;
        end else if (count_d > wm_q) begin
            wm_d = count_d;
        end
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            wm_q    <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            wm_q    <= wm_d;
        end
    end

    // Outputs decoded from registered state
    always_comb begin
        bus.ready_o      = ~full;
        bus.valid_o      = ~empty;
        bus.rdata        = mem_q[rptr_q[AW-1:0]];
        bus.count        = count_q;
        bus.watermark    = wm_q;
        bus.almost_full  = (count_q >= CW'(AFULL_THR));
        bus.almost_empty = (count_q <= CW'(AEMPTY_THR));
    end
endmodule
